// File: rtl/gate_settle_monitor.sv
// Watches a bank of emulated gate outputs and reports settling, oscillation
// timeout, a snapshot of the settled value and a saturating change count.
module gate_settle_monitor #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 64,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] nets,
    output logic             busy,
    output logic             settled,
    output logic             timeout,
    output logic [WIDTH-1:0] snapshot,
    output logic [CNT_W-1:0] change_count
);

    localparam int CYC_W = $clog2(TIMEOUT + 1);
    localparam logic [CYC_W-1:0] SETTLE_C  = CYC_W'(SETTLE_CYCLES);
    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WATCH,
        S_SETTLED,
        S_TIMEOUT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sample_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] snap_q;
    logic [CYC_W-1:0] stable_q, stable_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, settled_q, timeout_q;
    logic             settle_hit, timeout_hit;

    // Gates commit on the rising edge, so the falling edge sees their settled outputs.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
        end else begin
            sample_q <= nets;
        end
    end

    always_comb begin
        cycle_d  = cycle_q + CYC_ONE;
        stable_d = stable_q + CYC_ONE;
        count_d  = count_q;
        if (sample_q != last_q) begin
            stable_d = '0;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end
        end
        settle_hit  = (stable_d == SETTLE_C);
        timeout_hit = (cycle_d == TIMEOUT_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= '0;
            snap_q    <= '0;
            stable_q  <= '0;
            cycle_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_WATCH: begin
                    cycle_q  <= cycle_d;
                    stable_q <= stable_d;
                    count_q  <= count_d;
                    last_q   <= sample_q;
                    // A coincident settle and timeout resolves in favour of settle.
                    if (settle_hit) begin
                        state_q   <= S_SETTLED;
                        busy_q    <= 1'b0;
                        settled_q <= 1'b1;
                        snap_q    <= sample_q;
                    end else if (timeout_hit) begin
                        state_q   <= S_TIMEOUT;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= S_WATCH;
                        busy_q    <= 1'b1;
                        settled_q <= 1'b0;
                        timeout_q <= 1'b0;
                        last_q    <= sample_q;
                        stable_q  <= '0;
                        cycle_q   <= '0;
                        count_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign settled      = settled_q;
    assign timeout      = timeout_q;
    assign snapshot     = snap_q;
    assign change_count = count_q;

endmodule

// File: tb/tb_gate_settle_monitor.sv
// Scoreboard bench: each watch window's expected outcome is computed from the
// sequence of sampled net values and checked when the DUT finishes the window.
module tb_gate_settle_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] nets = '0;
    logic [15:0] nets2 = '0;
    logic        busy, settled, timeout;
    logic        busy2, settled2, timeout2;
    logic [15:0] snapshot, snapshot2;
    logic [7:0]  changeCount, changeCount2;

    typedef struct {
        bit          settled;
        bit          timeout;
        logic [15:0] snap;
        int          cnt;
        int          lat;
    } exp_t;

    int          testsRun = 0;
    int          failCount = 0;
    exp_t        expQ[$];
    logic [15:0] expSnap = '0;
    int          busyCnt = 0;
    bit          doneSeen = 1'b0;
    exp_t        monExp;

    gate_settle_monitor #(.WIDTH(16), .SETTLE_CYCLES(4), .TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .nets(nets),
        .busy(busy), .settled(settled), .timeout(timeout),
        .snapshot(snapshot), .change_count(changeCount)
    );

    gate_settle_monitor #(.WIDTH(16), .SETTLE_CYCLES(4), .TIMEOUT(5), .CNT_W(8)) dutShort (
        .clk(clk), .rst(rst), .start(start2), .nets(nets2),
        .busy(busy2), .settled(settled2), .timeout(timeout2),
        .snapshot(snapshot2), .change_count(changeCount2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // seq[k] is the value sampled before the k-th rising edge after entry (seq[0] is loaded at entry).
    function automatic exp_t predict(input logic [15:0] seq[$], input int s, input int t,
                                     input logic [15:0] prevSnap);
        exp_t e;
        int   changes;
        bit   same;
        e.settled = 1'b0;
        e.timeout = 1'b0;
        e.snap    = prevSnap;
        e.lat     = t;
        for (int k = s; k <= t; k++) begin
            same = 1'b1;
            for (int j = k - s; j < k; j++) begin
                if (seq[j] != seq[k]) same = 1'b0;
            end
            if (same) begin
                e.settled = 1'b1;
                e.lat     = k;
                break;
            end
        end
        if (!e.settled) e.timeout = 1'b1;
        changes = 0;
        for (int i = 1; i <= e.lat; i++) begin
            if (seq[i] != seq[i-1]) changes++;
        end
        e.cnt = (changes > 255) ? 255 : changes;
        if (e.settled) e.snap = seq[e.lat];
        return e;
    endfunction

    task automatic applyStimulus(input logic [15:0] seq[$], input bit midStart);
        exp_t e;
        e = predict(seq, 4, 64, expSnap);
        expQ.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        nets  = seq[0];
        @(posedge clk); #1;
        start = 1'b0;
        nets  = seq[1];
        checkOutput("entry_busy", 32'(busy), 32'd1);
        checkOutput("entry_settled", 32'(settled), 32'd0);
        checkOutput("entry_timeout", 32'(timeout), 32'd0);
        checkOutput("entry_snapshot", 32'(snapshot), 32'(expSnap));
        checkOutput("entry_count", 32'(changeCount), 32'd0);
        for (int k = 2; k <= e.lat + 2; k++) begin
            @(posedge clk); #1;
            nets  = seq[k];
            start = midStart && (k <= e.lat) && ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("hold_settled", 32'(settled), 32'(e.settled));
        checkOutput("hold_timeout", 32'(timeout), 32'(e.timeout));
        expSnap = e.snap;
    endtask

    // Monitor: counts busy cycles and scores each completed window once.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCnt  = 0;
                doneSeen = 1'b0;
            end else if (busy) begin
                busyCnt++;
                doneSeen = 1'b0;
            end else if ((settled || timeout) && !doneSeen) begin
                doneSeen = 1'b1;
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected_done: got settled=%0b timeout=%0b, expected no window",
                             settled, timeout);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("settled", 32'(settled), 32'(monExp.settled));
                    checkOutput("timeout", 32'(timeout), 32'(monExp.timeout));
                    checkOutput("snapshot", 32'(snapshot), 32'(monExp.snap));
                    checkOutput("change_count", 32'(changeCount), 32'(monExp.cnt));
                    checkOutput("latency", 32'(busyCnt), 32'(monExp.lat));
                end
                busyCnt = 0;
            end
        end
    end

    initial begin
        logic [15:0] seq[$];
        logic [15:0] v;
        exp_t        e2;
        int          kind;
        int          m;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_settled", 32'(settled), 32'd0);
        checkOutput("reset_timeout", 32'(timeout), 32'd0);
        checkOutput("reset_snapshot", 32'(snapshot), 32'd0);
        checkOutput("reset_count", 32'(changeCount), 32'd0);
        rst = 1'b0;

        seq = {};
        for (int i = 0; i < 70; i++) seq.push_back(16'h00A5);
        applyStimulus(seq, 1'b0);

        seq = {16'h00A5, 16'h0001, 16'h0003};
        for (int i = 3; i < 70; i++) seq.push_back(16'h0007);
        applyStimulus(seq, 1'b0);

        seq = {};
        for (int i = 0; i < 70; i++) seq.push_back(16'h1234);
        applyStimulus(seq, 1'b0);

        seq = {};
        for (int i = 0; i < 70; i++) seq.push_back((i % 2 == 0) ? 16'h0000 : 16'hFFFF);
        applyStimulus(seq, 1'b0);

        for (int w = 0; w < 12; w++) begin
            seq  = {};
            kind = $urandom_range(0, 3);
            v    = 16'($urandom);
            m    = $urandom_range(1, 8);
            for (int i = 0; i < 70; i++) begin
                case (kind)
                    0: seq.push_back(v);
                    1: seq.push_back((i <= m) ? 16'($urandom) : seq[m]);
                    2: seq.push_back((i % 2 == 0) ? v : ~v);
                    default: seq.push_back(16'($urandom_range(0, 1)));
                endcase
            end
            applyStimulus(seq, 1'b1);
        end

        // Abort a toggling window at cycle 10 with an asynchronous reset.
        @(posedge clk); #1;
        start = 1'b1;
        nets  = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        nets  = 16'hFFFF;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
            nets = ~nets;
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_settled", 32'(settled), 32'd0);
        checkOutput("abort_timeout", 32'(timeout), 32'd0);
        checkOutput("abort_snapshot", 32'(snapshot), 32'd0);
        checkOutput("abort_count", 32'(changeCount), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst     = 1'b0;
        expSnap = '0;

        seq = {};
        v   = 16'($urandom);
        for (int i = 0; i < 70; i++) seq.push_back(v);
        applyStimulus(seq, 1'b0);

        // Short-timeout instance: settle and timeout coincide, mid-window start ignored.
        seq = {16'h0F0F};
        for (int i = 1; i < 8; i++) seq.push_back(16'hF0F0);
        e2 = predict(seq, 4, 5, 16'h0000);
        @(posedge clk); #1;
        start2 = 1'b1;
        nets2  = seq[0];
        @(posedge clk); #1;
        start2 = 1'b0;
        nets2  = seq[1];
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            nets2  = seq[k];
            start2 = (k == 2) || (k == 3);
            if (k == 5) checkOutput("short_busy_e4", 32'(busy2), 32'd1);
            if (k == 6) begin
                checkOutput("short_settled", 32'(settled2), 32'(e2.settled));
                checkOutput("short_timeout", 32'(timeout2), 32'(e2.timeout));
                checkOutput("short_busy", 32'(busy2), 32'd0);
                checkOutput("short_count", 32'(changeCount2), 32'(e2.cnt));
                checkOutput("short_snapshot", 32'(snapshot2), 32'(e2.snap));
            end
        end
        start2 = 1'b0;

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
